pulse_wave_gen: RTL and testbench

Programmable-period, programmable-duty pulse/square sample generator for the synthesis datapath. Period, duty, amplitude and polarity mode load at runtime through a config handshake. Config changes take effect only at a period boundary, so the output has no glitches. Samples stream out on a valid/ready interface toward the mixer/DAC path, one sample per accepted transfer.

---
 rtl/pulse_wave_gen_if.sv | 29 ++
 rtl/pulse_wave_gen.sv | 146 ++++++++++++++
 tb/tb_pulse_wave_gen.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_wave_gen_if.sv
// Config and sample-stream bundle for pulse_wave_gen.
// The master side is the generator; the slave side feeds config and drains samples.
interface pulse_wave_gen_if #(
  parameter int width_p        = 12,
  parameter int period_width_p = 16
);
  logic                      cfg_valid_i;
  logic                      cfg_ready_o;
  logic [period_width_p-1:0] cfg_period_i;
  logic [period_width_p-1:0] cfg_duty_i;
  logic [width_p-2:0]        cfg_amp_i;
  logic                      cfg_bipolar_i;
  logic                      ready_i;
  logic                      valid_o;
  logic [width_p-1:0]        data_o;
  logic                      cycle_start_o;

  modport master (
    input  cfg_valid_i, cfg_period_i, cfg_duty_i,
    input  cfg_amp_i, cfg_bipolar_i, ready_i,
    output cfg_ready_o, valid_o, data_o, cycle_start_o
  );

  modport slave (
    output cfg_valid_i, cfg_period_i, cfg_duty_i,
    output cfg_amp_i, cfg_bipolar_i, ready_i,
    input  cfg_ready_o, valid_o, data_o, cycle_start_o
  );
endinterface

// File: rtl/pulse_wave_gen.sv
// Programmable period/duty pulse sample generator.
// Config changes are deferred to the period boundary so the wave never glitches.
module pulse_wave_gen #(
  parameter int width_p        = 12,
  parameter int period_width_p = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  pulse_wave_gen_if.master  io
);
  localparam int pw_lp = period_width_p;
  localparam logic [pw_lp-1:0] one_lp = pw_lp'(1);
  localparam logic [pw_lp-1:0] two_lp = pw_lp'(2);

  typedef struct packed {
    logic [pw_lp-1:0]   p;
    logic [pw_lp-1:0]   d;
    logic [width_p-2:0] a;
    logic               b;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e           state_q, state_d;
  cfg_t             act_q, act_d;
  cfg_t             pend_q, pend_d;
  logic [pw_lp-1:0] phase_q, phase_d;
  logic [width_p-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             cs_q, cs_d;
  logic             cfg_ready_q, cfg_ready_d;

  cfg_t             new_cfg;
  cfg_t             nxt_cfg;
  logic             cfg_hs;
  logic             smp_hs;
  logic             last;

  // Duty needs no clamp: phase < P always, so D >= P reads as constant high.
  function automatic cfg_t norm_f(
    input logic [pw_lp-1:0]   p,
    input logic [pw_lp-1:0]   d,
    input logic [width_p-2:0] a,
    input logic               b
  );
    cfg_t n;
    n.p = (p < two_lp) ? two_lp : p;
    n.d = d;
    n.a = a;
    n.b = b;
    return n;
  endfunction

  function automatic logic [width_p-1:0] sample_f(
    input cfg_t             c,
    input logic [pw_lp-1:0] ph
  );
    logic [width_p-1:0] mag;
    mag = {1'b0, c.a};
    if (ph < c.d)  return mag;
    else if (c.b)  return -mag;
    else           return '0;
  endfunction

  assign new_cfg = norm_f(io.cfg_period_i, io.cfg_duty_i,
                          io.cfg_amp_i, io.cfg_bipolar_i);
  assign cfg_hs  = io.cfg_valid_i & cfg_ready_q;
  assign smp_hs  = valid_q & io.ready_i;
  assign last    = (phase_q == act_q.p - one_lp);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    phase_d = phase_q;
    data_d  = data_q;
    cs_d    = cs_q;
    nxt_cfg = act_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          act_d   = new_cfg;
          phase_d = '0;
          data_d  = sample_f(new_cfg, '0);
          cs_d    = 1'b1;
          state_d = RUN;
        end
      end
      RUN, PEND: begin
        if (smp_hs && last) begin
          if (state_q == PEND) nxt_cfg = pend_q;
          else if (cfg_hs)     nxt_cfg = new_cfg;
          act_d   = nxt_cfg;
          phase_d = '0;
          data_d  = sample_f(nxt_cfg, '0);
          cs_d    = 1'b1;
          state_d = RUN;
        end else begin
          if (smp_hs) begin
            phase_d = phase_q + one_lp;
            data_d  = sample_f(act_q, phase_q + one_lp);
            cs_d    = 1'b0;
          end
          if (state_q == RUN && cfg_hs) begin
            pend_d  = new_cfg;
            state_d = PEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d     = (state_d != IDLE);
    cfg_ready_d = (state_d != PEND);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      phase_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      cs_q        <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      phase_q     <= phase_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      cs_q        <= cs_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign io.cfg_ready_o   = cfg_ready_q;
  assign io.valid_o       = valid_q;
  assign io.data_o        = data_q;
  assign io.cycle_start_o = cs_q;
endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed bench for pulse_wave_gen.
// Each task drives one scenario and checks outputs #1 after the rising edge.
module tb_pulse_wave_gen;
  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pulse_wave_gen_if #(.width_p(12), .period_width_p(16)) io ();

  pulse_wave_gen #(.width_p(12), .period_width_p(16)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .io      (io.master)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [11:0] P100 = 12'd100;
  localparam logic [11:0] N100 = 12'hF9C;
  localparam logic [11:0] P50  = 12'd50;
  localparam logic [11:0] N50  = 12'hFCE;
  localparam logic [11:0] P10  = 12'd10;
  localparam logic [11:0] N10  = 12'hFF6;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    io.cfg_valid_i   = 1'b0;
    io.cfg_period_i  = '0;
    io.cfg_duty_i    = '0;
    io.cfg_amp_i     = '0;
    io.cfg_bipolar_i = 1'b0;
    io.ready_i       = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
  endtask

  task automatic set_cfg(input int p, input int d, input int a, input bit b);
    io.cfg_period_i  = 16'(p);
    io.cfg_duty_i    = 16'(d);
    io.cfg_amp_i     = 11'(a);
    io.cfg_bipolar_i = b;
    io.cfg_valid_i   = 1'b1;
  endtask

  // Offer a config in IDLE and land on the phase-0 sample.
  task automatic start(input int p, input int d, input int a, input bit b);
    set_cfg(p, d, a, b);
    io.ready_i = 1'b1;
    step();
    io.cfg_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (io.valid_o !== 1'b0 || io.data_o !== 12'd0 ||
        io.cycle_start_o !== 1'b0 || io.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset: v=%b d=%h cs=%b rdy=%b, want 0 000 0 1",
               io.valid_o, io.data_o, io.cycle_start_o, io.cfg_ready_o);
    end
  endtask

  task automatic test_basic();
    logic [11:0] exp_d [4];
    exp_d = '{P100, P100, N100, N100};
    do_reset();
    start(4, 2, 100, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (io.valid_o !== 1'b1 || io.data_o !== exp_d[i%4] ||
          io.cycle_start_o !== (i % 4 == 0)) begin
        errors++;
        $display("FAIL basic[%0d]: v=%b d=%h cs=%b, want 1 %h %b",
                 i, io.valid_o, io.data_o, io.cycle_start_o,
                 exp_d[i%4], (i % 4 == 0));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat;
    logic [11:0] cur;
    logic        cur_cs;
    bit          rdy;
    int          k;
    pat = 16'b1011_0011_1000_1101;
    k = 0;
    do_reset();
    start(5, 1, 2047, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cur    = io.data_o;
      cur_cs = io.cycle_start_o;
      rdy    = pat[i%16];
      io.ready_i = rdy;
      step();
      checks++;
      if (rdy) begin
        if (cur !== ((k % 5 == 0) ? 12'd2047 : 12'd0) ||
            cur_cs !== (k % 5 == 0)) begin
          errors++;
          $display("FAIL bp_accept[%0d]: d=%h cs=%b, want %h %b", k, cur,
                   cur_cs, (k % 5 == 0) ? 12'd2047 : 12'd0, (k % 5 == 0));
        end
        k++;
      end else if (io.data_o !== cur || io.cycle_start_o !== cur_cs) begin
        errors++;
        $display("FAIL bp_hold[%0d]: d=%h cs=%b, want %h %b", i,
                 io.data_o, io.cycle_start_o, cur, cur_cs);
      end
    end
    io.ready_i = 1'b1;
  endtask

  task automatic test_reconfig();
    logic [11:0] exp_d [6];
    logic        exp_r [6];
    logic        exp_c [6];
    exp_d = '{N100, N100, P50, N50, P50, N50};
    exp_r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    start(4, 2, 100, 1'b1);
    step();
    checks++;
    if (io.data_o !== P100 || io.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_ph1: d=%h rdy=%b, want %h 1",
               io.data_o, io.cfg_ready_o, P100);
    end
    set_cfg(2, 1, 50, 1'b1);
    step();
    io.cfg_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (io.data_o !== exp_d[i] || io.cfg_ready_o !== exp_r[i] ||
          io.cycle_start_o !== exp_c[i]) begin
        errors++;
        $display("FAIL reconfig[%0d]: d=%h rdy=%b cs=%b, want %h %b %b", i,
                 io.data_o, io.cfg_ready_o, io.cycle_start_o,
                 exp_d[i], exp_r[i], exp_c[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_d [4];
    exp_d = '{P50, 12'd0, P50, 12'd0};
    do_reset();
    start(4, 2, 100, 1'b1);
    step();
    step();
    step();
    checks++;
    if (io.data_o !== N100 || io.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ph3: d=%h rdy=%b, want %h 1",
               io.data_o, io.cfg_ready_o, N100);
    end
    set_cfg(2, 1, 50, 1'b0);
    step();
    io.cfg_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io.data_o !== exp_d[i] || io.cfg_ready_o !== 1'b1 ||
          io.cycle_start_o !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL b2b[%0d]: d=%h rdy=%b cs=%b, want %h 1 %b", i,
                 io.data_o, io.cfg_ready_o, io.cycle_start_o,
                 exp_d[i], (i % 2 == 0));
      end
      step();
    end
  endtask

  task automatic test_clamp();
    do_reset();
    start(0, 7, 10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io.data_o !== P10 || io.cycle_start_o !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL clamp_hi[%0d]: d=%h cs=%b, want %h %b", i,
                 io.data_o, io.cycle_start_o, P10, (i % 2 == 0));
      end
      step();
    end
    do_reset();
    start(1, 0, 10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io.data_o !== N10 || io.cycle_start_o !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL clamp_lo[%0d]: d=%h cs=%b, want %h %b", i,
                 io.data_o, io.cycle_start_o, N10, (i % 2 == 0));
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    start(4, 2, 100, 1'b1);
    set_cfg(2, 1, 50, 1'b1);
    step();
    io.cfg_valid_i = 1'b0;
    checks++;
    if (io.cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_pend: rdy=%b, want 0", io.cfg_ready_o);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (io.valid_o !== 1'b0 || io.data_o !== 12'd0 ||
        io.cycle_start_o !== 1'b0 || io.cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_now: v=%b d=%h cs=%b rdy=%b, want 0 000 0 1",
               io.valid_o, io.data_o, io.cycle_start_o, io.cfg_ready_o);
    end
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (io.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL areset_idle[%0d]: v=%b, want 0", i, io.valid_o);
      end
    end
    start(4, 1, 7, 1'b0);
    checks++;
    if (io.valid_o !== 1'b1 || io.data_o !== 12'd7 ||
        io.cycle_start_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_restart: v=%b d=%h cs=%b, want 1 007 1",
               io.valid_o, io.data_o, io.cycle_start_o);
    end
    step();
    checks++;
    if (io.data_o !== 12'd0 || io.cycle_start_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_next: d=%h cs=%b, want 000 0",
               io.data_o, io.cycle_start_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reconfig();
    test_back_to_back();
    test_clamp();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
